// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte producers.
// Tracks the transmitter busy handshake, detects lost starts, counts bytes.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              busy_in,
    output logic [2:0]        grant_id,
    output logic              active,
    output logic              timeout,
    output logic [15:0]       byte_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    localparam int          CW      = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(START_TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      last_grant_q, last_grant_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            timeout_q, timeout_d;
    logic            active_q, active_d;
    logic [15:0]     byte_count_q, byte_count_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            win_found;
    logic [2:0]      win_idx;
    logic [7:0]      win_byte;
    logic [NREQ-1:0] win_oh;
    int              rr_idx;

    // Search starts just past the previous winner so a requester that keeps
    // req high is served again only after everyone else pending.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant_q;
        win_byte  = 8'h00;
        win_oh    = '0;
        rr_idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = (int'(last_grant_q) + i) % NREQ;
            if (!win_found && req[rr_idx]) begin
                win_found      = 1'b1;
                win_idx        = 3'(rr_idx);
                win_byte       = req_data[8*rr_idx +: 8];
                win_oh[rr_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        ack_d        = '0;
        timeout_d    = 1'b0;
        byte_count_d = byte_count_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found && !busy_in) begin
                    tx_data_d    = win_byte;
                    tx_start_d   = 1'b1;
                    ack_d        = win_oh;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    cnt_d        = '0;
                    state_d      = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // A busy rise on the expiry edge still counts as accepted.
                if (busy_in) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_in) begin
                    byte_count_d = byte_count_q + 16'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 3'(NREQ - 1);
            grant_id_q   <= 3'd0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            ack_q        <= '0;
            timeout_q    <= 1'b0;
            active_q     <= 1'b0;
            byte_count_q <= 16'd0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            ack_q        <= ack_d;
            timeout_q    <= timeout_d;
            active_q     <= active_d;
            byte_count_q <= byte_count_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ack        = ack_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_id_q;
    assign active     = active_q;
    assign timeout    = timeout_q;
    assign byte_count = byte_count_q;

endmodule
